// File: rtl/cart_capture_pkg.sv
// Shared types and record layout for the cartridge capture decoder.
package cart_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_READ
   } state_t;

   localparam int REC_W         = 49;
   localparam int REC_DATA_LSB  = 0;
   localparam int REC_DATA_W    = 16;
   localparam int REC_ADDR_LSB  = 16;
   localparam int REC_ADDR_W    = 32;
   localparam int REC_FIRST_BIT = 48;

   function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] addr,
                                                 input logic [15:0] data,
                                                 input logic        first);
      return {first, addr, data};
   endfunction

endpackage

// File: rtl/cart_capture_decoder_if.sv
// Cart bus inputs plus the record stream and status flags of the capture decoder.
interface cart_capture_decoder_if;

   logic [15:0] cart_ad_sync;
   logic        cart_rd_sync;
   logic        cart_alel_sync;
   logic        cart_aleh_sync;
   logic [31:0] rec_addr;
   logic [15:0] rec_data;
   logic        rec_first;
   logic        rec_valid;
   logic        rec_ready;
   logic        overflow;
   logic        proto_err;
   logic        clr_flags;

   modport slave (
      input  cart_ad_sync, cart_rd_sync, cart_alel_sync, cart_aleh_sync,
      input  rec_ready, clr_flags,
      output rec_addr, rec_data, rec_first, rec_valid, overflow, proto_err
   );

   modport master (
      output cart_ad_sync, cart_rd_sync, cart_alel_sync, cart_aleh_sync,
      output rec_ready, clr_flags,
      input  rec_addr, rec_data, rec_first, rec_valid, overflow, proto_err
   );

endinterface

// File: rtl/cart_capture_fifo.sv
// Show-ahead synchronous record FIFO with a registered head; head holds the last popped record when empty.
module cart_capture_fifo
   import cart_capture_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [REC_W-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [REC_W-1:0] o_rdata,
   output logic             o_drop
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [REC_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic [REC_W-1:0] r_rdata;

   logic             w_pop, w_full, w_push_ok;
   logic [AW-1:0]    w_rd_ptr_nxt;
   logic [CW-1:0]    w_count_nxt, w_remain;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
   assign w_pop        = i_pop & r_valid;
   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_push_ok    = i_push & (~w_full | w_pop);
   assign o_drop       = i_push & ~w_push_ok;
   assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
   assign w_remain     = r_count - CW'(w_pop);
   assign w_count_nxt  = w_remain + CW'(w_push_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_valid  <= (w_count_nxt != '0);
         // Bypass the incoming record when it becomes the new head of an otherwise empty FIFO
         if (w_count_nxt != '0) begin
            if (w_remain == '0) r_rdata <= i_wdata;
            else                r_rdata <= r_mem[w_rd_ptr_nxt];
         end
      end
   end

   assign o_valid = r_valid;
   assign o_rdata = r_rdata;

endmodule

// File: rtl/cart_capture_decoder.sv
// Decodes N64 PI cartridge reads (ALE_H/ALE_L address phases, /RD burst) into {address, data} records.
module cart_capture_decoder
   import cart_capture_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_STEP  = 2
) (
   input logic                   clk,
   input logic                   reset,
   cart_capture_decoder_if.slave bus
);

   logic [15:0]      r_ad_d;
   logic             r_rd_d, r_alel_d, r_aleh_d;
   logic             w_rd_rise, w_aleh_rise, w_aleh_fall, w_alel_fall;
   state_t           r_state, w_state_nxt;
   logic             w_push, w_load_hi, w_load_lo, w_err_set, w_drop;
   logic [31:0]      r_addr;
   logic             r_first, r_overflow, r_proto_err;
   logic [REC_W-1:0] w_rec_in, w_rec_out;
   logic             w_rec_valid;

   // Previous-cycle copies; r_ad_d still carries data from the last cycle /RD was low
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ad_d   <= '0;
         r_rd_d   <= 1'b0;
         r_alel_d <= 1'b0;
         r_aleh_d <= 1'b0;
      end else begin
         r_ad_d   <= bus.cart_ad_sync;
         r_rd_d   <= bus.cart_rd_sync;
         r_alel_d <= bus.cart_alel_sync;
         r_aleh_d <= bus.cart_aleh_sync;
      end
   end

   assign w_rd_rise   =  bus.cart_rd_sync   & ~r_rd_d;
   assign w_aleh_rise =  bus.cart_aleh_sync & ~r_aleh_d;
   assign w_aleh_fall = ~bus.cart_aleh_sync &  r_aleh_d;
   assign w_alel_fall = ~bus.cart_alel_sync &  r_alel_d;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_load_hi   = 1'b0;
      w_load_lo   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         ST_IDLE: if (w_aleh_rise) w_state_nxt = ST_ADDR_H;
         ST_ADDR_H: begin
            if (w_aleh_fall) begin
               if (bus.cart_alel_sync) begin
                  w_load_hi   = 1'b1;
                  w_state_nxt = ST_ADDR_L;
               end else begin
                  w_err_set   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_ADDR_L: begin
            if (w_alel_fall) begin
               w_load_lo   = 1'b1;
               w_state_nxt = ST_READ;
            end else if (w_aleh_rise) begin
               w_state_nxt = ST_ADDR_H;
            end
         end
         ST_READ: begin
            // A final word whose /RD rise meets a new ALE_H rise is still captured
            if (w_rd_rise)   w_push      = 1'b1;
            if (w_aleh_rise) w_state_nxt = ST_ADDR_H;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr  <= '0;
         r_first <= 1'b0;
      end else begin
         if (w_load_hi) r_addr[31:16] <= r_ad_d;
         if (w_load_lo) begin
            r_addr[15:0] <= r_ad_d;
            r_first      <= 1'b1;
         end
         if (w_push) begin
            r_addr  <= r_addr + 32'(ADDR_STEP);
            r_first <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_drop)             r_overflow  <= 1'b1;
         else if (bus.clr_flags) r_overflow  <= 1'b0;
         if (w_err_set)          r_proto_err <= 1'b1;
         else if (bus.clr_flags) r_proto_err <= 1'b0;
      end
   end

   assign w_rec_in = pack_rec(r_addr, r_ad_d, r_first);

   cart_capture_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_rec_in),
      .i_pop   (bus.rec_ready),
      .o_valid (w_rec_valid),
      .o_rdata (w_rec_out),
      .o_drop  (w_drop)
   );

   assign bus.rec_valid = w_rec_valid;
   assign bus.rec_addr  = w_rec_out[REC_ADDR_LSB +: REC_ADDR_W];
   assign bus.rec_data  = w_rec_out[REC_DATA_LSB +: REC_DATA_W];
   assign bus.rec_first = w_rec_out[REC_FIRST_BIT];
   assign bus.overflow  = r_overflow;
   assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_cart_capture_decoder.sv
// Scoreboard bench for cart_capture_decoder: bus-level stimulus, record stream checked in order.
module tb_cart_capture_decoder;

   localparam int FIFO_DEPTH = 16;
   localparam int ADDR_STEP  = 2;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      logic        first;
   } rec_t;

   logic clk;
   logic reset;
   rec_t q[$];
   int   n_cmp;
   int   n_err;
   logic [31:0] exp_addr;
   logic        exp_first;

   cart_capture_decoder_if bus ();

   cart_capture_decoder #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_STEP  (ADDR_STEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record monitor: a transfer happens at the next rising edge
   always @(negedge clk) begin
      if (reset && bus.rec_valid && bus.rec_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_record got addr=%h data=%h first=%b required none",
                     bus.rec_addr, bus.rec_data, bus.rec_first);
         end else begin
            rec_t e;
            e = q.pop_front();
            if ({bus.rec_addr, bus.rec_data, bus.rec_first} !== {e.addr, e.data, e.first}) begin
               n_err++;
               $display("FAIL record got addr=%h data=%h first=%b required addr=%h data=%h first=%b",
                        bus.rec_addr, bus.rec_data, bus.rec_first, e.addr, e.data, e.first);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [15:0] hi, input logic [15:0] lo, input bit aleh_already);
      if (!aleh_already) begin
         bus.cart_aleh_sync = 1'b1;
         tick(3);
      end
      bus.cart_alel_sync = 1'b1;
      bus.cart_ad_sync   = hi;
      tick(3);
      bus.cart_aleh_sync = 1'b0;
      tick(3);
      bus.cart_ad_sync   = lo;
      tick(3);
      bus.cart_alel_sync = 1'b0;
      tick(3);
      exp_addr  = {hi, lo};
      exp_first = 1'b1;
   endtask

   task automatic read_word(input logic [15:0] d, input bit expect_rec, input bit aleh_on_rise,
                            input bit clr_on_rise, input bit ready_on_rise);
      rec_t r;
      bus.cart_ad_sync = d;
      bus.cart_rd_sync = 1'b0;
      tick(3);
      bus.cart_rd_sync = 1'b1;
      if (aleh_on_rise)  bus.cart_aleh_sync = 1'b1;
      if (clr_on_rise)   bus.clr_flags      = 1'b1;
      if (ready_on_rise) bus.rec_ready      = 1'b1;
      if (expect_rec) begin
         if (q.size() < FIFO_DEPTH || ready_on_rise) begin
            r.addr  = exp_addr;
            r.data  = d;
            r.first = exp_first;
            q.push_back(r);
         end
         exp_addr  = exp_addr + 32'(ADDR_STEP);
         exp_first = 1'b0;
      end
      tick(1);
      bus.clr_flags = 1'b0;
      tick(2);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && (q.size() != 0 || bus.rec_valid); i++) tick(1);
      n_cmp++;
      if (q.size() != 0 || bus.rec_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_drain got pending=%0d rec_valid=%b required pending=0 rec_valid=0",
                  name, q.size(), bus.rec_valid);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick(2);
      n_cmp++; if (bus.rec_valid !== 1'b0)     begin n_err++; $display("FAIL reset_valid got %b required 0", bus.rec_valid); end
      n_cmp++; if (bus.rec_addr !== 32'h0)     begin n_err++; $display("FAIL reset_addr got %h required 0", bus.rec_addr); end
      n_cmp++; if (bus.rec_data !== 16'h0)     begin n_err++; $display("FAIL reset_data got %h required 0", bus.rec_data); end
      n_cmp++; if (bus.rec_first !== 1'b0)     begin n_err++; $display("FAIL reset_first got %b required 0", bus.rec_first); end
      n_cmp++; if (bus.overflow !== 1'b0)      begin n_err++; $display("FAIL reset_overflow got %b required 0", bus.overflow); end
      n_cmp++; if (bus.proto_err !== 1'b0)     begin n_err++; $display("FAIL reset_proto_err got %b required 0", bus.proto_err); end
      reset = 1'b1;
      tick(2);
   endtask

   task automatic test_basic;
      addr_phase(16'h1000, 16'h0040, 1'b0);
      read_word(16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h00A2, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h00A3, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h00A4, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_drain("basic");
      n_cmp++; if (bus.rec_data !== 16'h00A4)     begin n_err++; $display("FAIL hold_data got %h required 00a4", bus.rec_data); end
      n_cmp++; if (bus.rec_addr !== 32'h10000046) begin n_err++; $display("FAIL hold_addr got %h required 10000046", bus.rec_addr); end
   endtask

   task automatic test_overflow;
      bus.rec_ready = 1'b0;
      addr_phase(16'h2000, 16'h0000, 1'b0);
      for (int i = 0; i < FIFO_DEPTH + 3; i++) read_word(16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_set got %b required 1", bus.overflow); end
      n_cmp++; if (bus.rec_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b required 1", bus.rec_valid); end
      bus.clr_flags = 1'b1;
      tick(1);
      bus.clr_flags = 1'b0;
      n_cmp++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL ovf_clear got %b required 0", bus.overflow); end
      // drop coincides with clr_flags: the set must win
      read_word(16'h0200, 1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (bus.overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_set_wins got %b required 1", bus.overflow); end
      bus.clr_flags = 1'b1;
      tick(1);
      bus.clr_flags = 1'b0;
      n_cmp++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL ovf_clear2 got %b required 0", bus.overflow); end
      // push while full with a simultaneous pop is accepted
      read_word(16'h0300, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL full_push_pop got overflow=%b required 0", bus.overflow); end
      wait_drain("overflow");
   endtask

   task automatic test_wrap;
      addr_phase(16'hFFFF, 16'hFFFE, 1'b0);
      read_word(16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_drain("wrap");
      n_cmp++; if (bus.rec_addr !== 32'h00000000) begin n_err++; $display("FAIL wrap_addr got %h required 00000000", bus.rec_addr); end
   endtask

   task automatic test_proto_err;
      bus.cart_aleh_sync = 1'b1;
      tick(3);
      bus.cart_ad_sync = 16'h3000;
      tick(3);
      bus.cart_aleh_sync = 1'b0;
      tick(3);
      n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err_set got %b required 1", bus.proto_err); end
      read_word(16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
      read_word(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      n_cmp++; if (bus.rec_valid !== 1'b0) begin n_err++; $display("FAIL proto_no_rec got %b required 0", bus.rec_valid); end
      bus.clr_flags = 1'b1;
      tick(1);
      bus.clr_flags = 1'b0;
      n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL proto_err_clear got %b required 0", bus.proto_err); end
      addr_phase(16'h3000, 16'h0010, 1'b0);
      read_word(16'h0C01, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h0C02, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_drain("proto_recover");
   endtask

   task automatic test_reset_mid_burst;
      bus.rec_ready = 1'b0;
      addr_phase(16'h4000, 16'h0000, 1'b0);
      read_word(16'h0D01, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h0D02, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.rec_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre got %b required 1", bus.rec_valid); end
      reset = 1'b0;
      q.delete();
      tick(1);
      n_cmp++; if (bus.rec_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_valid got %b required 0", bus.rec_valid); end
      n_cmp++; if (bus.rec_addr !== 32'h0)  begin n_err++; $display("FAIL midrst_addr got %h required 0", bus.rec_addr); end
      reset = 1'b1;
      bus.rec_ready = 1'b1;
      tick(1);
      read_word(16'h0D03, 1'b0, 1'b0, 1'b0, 1'b0);
      read_word(16'h0D04, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      n_cmp++; if (bus.rec_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_ignored got %b required 0", bus.rec_valid); end
      addr_phase(16'h4000, 16'h0100, 1'b0);
      read_word(16'h0D05, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_drain("midrst_recover");
   endtask

   task automatic test_back_to_back;
      addr_phase(16'h5000, 16'h0000, 1'b0);
      read_word(16'h0B01, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h0B02, 1'b1, 1'b1, 1'b0, 1'b0);
      addr_phase(16'h6000, 16'h0020, 1'b1);
      read_word(16'h0C11, 1'b1, 1'b0, 1'b0, 1'b0);
      read_word(16'h0C12, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_drain("back_to_back");
      n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL b2b_proto_err got %b required 0", bus.proto_err); end
   endtask

   initial begin
      n_cmp              = 0;
      n_err              = 0;
      exp_addr           = '0;
      exp_first          = 1'b0;
      reset              = 1'b0;
      bus.cart_ad_sync   = '0;
      bus.cart_rd_sync   = 1'b1;
      bus.cart_alel_sync = 1'b0;
      bus.cart_aleh_sync = 1'b0;
      bus.rec_ready      = 1'b1;
      bus.clr_flags      = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_wrap();
      test_proto_err();
      test_reset_mid_burst();
      test_back_to_back();
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
